// File: rtl/text_buffer_ctrl.sv
// Text-mode cursor/RAM write controller: turns received UART bytes into text RAM
// writes and cursor moves, sweeps the screen on clear, and echoes accepted bytes.
module text_buffer_ctrl #(
    parameter int COL_W     = 5,
    parameter int ROW_W     = 2,
    parameter int COL_START = 24,
    parameter int HOME_ROW  = 1,
    parameter int ECHO      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             clear_req,
    input  logic             tx_busy,
    output logic             ram_we,
    output logic [ROW_W-1:0] ram_row,
    output logic [COL_W-1:0] ram_col,
    output logic [7:0]       ram_wdata,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic             busy,
    output logic             rx_drop,
    output logic             tx_start,
    output logic [7:0]       tx_data
);
    localparam int CELL_W = ROW_W + COL_W;
    localparam logic [COL_W-1:0]  COL_HOME = COL_W'(COL_START);
    localparam logic [ROW_W-1:0]  ROW_HOME = ROW_W'(HOME_ROW);
    localparam logic [CELL_W-1:0] LAST     = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state, state_d;
    logic               cr_flag, pending, fire, is_print;
    logic [CELL_W-1:0]  cnt;
    logic [COL_W-1:0]   col_inc, col_dec;
    logic [ROW_W-1:0]   row_inc, row_bs;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (clear_req) state_d = CLEAR;
            CLEAR:   if (cnt == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign is_print = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
    assign col_inc  = cur_col + COL_W'(1);
    assign col_dec  = cur_col - COL_W'(1);
    assign row_inc  = cur_row + ROW_W'(1);
    // Backspacing off the first visible column wraps to the previous row.
    assign row_bs   = (cur_col == COL_HOME) ? cur_row - ROW_W'(1) : cur_row;
    assign fire     = (ECHO != 0) && pending && !tx_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_col   <= COL_HOME;
            cur_row   <= ROW_HOME;
            cr_flag   <= 1'b0;
            pending   <= 1'b0;
            cnt       <= '0;
            ram_we    <= 1'b0;
            ram_row   <= '0;
            ram_col   <= '0;
            ram_wdata <= 8'h00;
            busy      <= 1'b0;
            rx_drop   <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            state    <= state_d;
            ram_we   <= 1'b0;
            rx_drop  <= 1'b0;
            tx_start <= fire;
            if (fire) pending <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        busy    <= 1'b1;
                        cnt     <= '0;
                        rx_drop <= rx_valid;
                    end else if (rx_valid) begin
                        cr_flag <= (rx_data == 8'h0D);
                        // An accept coinciding with a launch replaces the byte
                        // being launched, so it is sent once and not re-queued.
                        if (ECHO != 0) begin
                            tx_data <= rx_data;
                            pending <= !fire;
                        end
                        if (is_print) begin
                            ram_we    <= 1'b1;
                            ram_row   <= cur_row;
                            ram_col   <= cur_col;
                            ram_wdata <= rx_data;
                            cur_col   <= col_inc;
                            if (col_inc == COL_HOME) cur_row <= row_inc;
                        end else if (rx_data == 8'h0D || (rx_data == 8'h0A && !cr_flag)) begin
                            cur_col <= COL_HOME;
                            cur_row <= row_inc;
                        end else if (rx_data == 8'h08) begin
                            ram_we    <= 1'b1;
                            ram_row   <= row_bs;
                            ram_col   <= col_dec;
                            ram_wdata <= 8'h20;
                            cur_col   <= col_dec;
                            cur_row   <= row_bs;
                        end
                    end
                end
                CLEAR: begin
                    ram_we               <= 1'b1;
                    ram_wdata            <= 8'h20;
                    {ram_row, ram_col}   <= cnt;
                    cnt                  <= cnt + CELL_W'(1);
                    rx_drop              <= rx_valid;
                    if (cnt == LAST) begin
                        busy    <= 1'b0;
                        cnt     <= '0;
                        cur_row <= ROW_HOME;
                        cur_col <= COL_HOME;
                        cr_flag <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed + randomized bench for text_buffer_ctrl against a cursor/screen reference model.
module tb_text_buffer_ctrl;
    localparam int NC = 32, NR = 4, CS = 24, HR = 1, CELLS = NC * NR;

    logic       clk = 0, reset = 1, rx_valid = 0, clear_req = 0, tx_busy = 0;
    logic [7:0] rx_data = 0;
    logic       ram_we, busy, rx_drop, tx_start;
    logic [1:0] ram_row, cur_row;
    logic [4:0] ram_col, cur_col;
    logic [7:0] ram_wdata, tx_data;

    int vectors = 0, errs = 0;
    int mrow = HR, mcol = CS;
    bit mcr = 0;

    text_buffer_ctrl dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .clear_req(clear_req), .tx_busy(tx_busy), .ram_we(ram_we), .ram_row(ram_row),
        .ram_col(ram_col), .ram_wdata(ram_wdata), .cur_row(cur_row), .cur_col(cur_col),
        .busy(busy), .rx_drop(rx_drop), .tx_start(tx_start), .tx_data(tx_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cur(input string tag, input int r, input int c);
        check({tag, "_row"}, 32'(cur_row), r);
        check({tag, "_col"}, 32'(cur_col), c);
    endtask

    // One accepted byte: drive it, then compare the write and cursor with the model.
    task automatic step(input logic [7:0] b);
        bit we_e = 0;
        int r_e = 0, c_e = 0;
        logic [7:0] d_e = 0;
        rx_valid = 1; rx_data = b;
        @(negedge clk);
        rx_valid = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            we_e = 1; r_e = mrow; c_e = mcol; d_e = b;
            mcol = (mcol + 1) % NC;
            if (mcol == CS) mrow = (mrow + 1) % NR;
            mcr = 0;
        end else if (b == 8'h0D) begin
            mcol = CS; mrow = (mrow + 1) % NR; mcr = 1;
        end else if (b == 8'h0A) begin
            if (!mcr) begin mcol = CS; mrow = (mrow + 1) % NR; end
            mcr = 0;
        end else if (b == 8'h08) begin
            if (mcol == CS) begin mcol = (CS - 1 + NC) % NC; mrow = (mrow + NR - 1) % NR; end
            else mcol = mcol - 1;
            we_e = 1; r_e = mrow; c_e = mcol; d_e = 8'h20;
            mcr = 0;
        end else mcr = 0;
        check("ram_we", 32'(ram_we), 32'(we_e));
        if (we_e) begin
            check("ram_row", 32'(ram_row), r_e);
            check("ram_col", 32'(ram_col), c_e);
            check("ram_wdata", 32'(ram_wdata), 32'(d_e));
        end
        check_cur("cursor", mrow, mcol);
        check("tx_data", 32'(tx_data), 32'(b));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_we", 32'(ram_we), 0);
            check("idle_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        int sel, busy_cnt, wr_cnt, txc;
        logic [7:0] b;
        bit seen [CELLS];

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_we", 32'(ram_we), 0);
        check("rst_addr", {ram_row, ram_col, ram_wdata}, 0);
        check("rst_flags", {busy, rx_drop, tx_start}, 0);
        check("rst_txd", 32'(tx_data), 0);
        check_cur("rst_cur", HR, CS);
        reset = 0;
        @(negedge clk);

        // 'A' with echo
        step(8'h41);
        check("echo_early", 32'(tx_start), 0);
        @(negedge clk);
        check("echo_start", 32'(tx_start), 1);
        check("echo_data", 32'(tx_data), 32'h41);
        @(negedge clk);
        check("echo_once", 32'(tx_start), 0);
        tx_busy = 1;

        // Wrap boundaries
        repeat (6) step(8'h61);
        check_cur("at_1_31", 1, 31);
        step(8'h62);
        check_cur("wrap_1_0", 1, 0);
        repeat (23) step(8'h63);
        check_cur("at_1_23", 1, 23);
        step(8'h64);
        check_cur("wrap_2_24", 2, 24);
        step(8'h0D);
        repeat (31) step(8'h65);
        check_cur("at_3_23", 3, 23);
        step(8'h66);
        check_cur("wrap_0_24", 0, 24);

        // CR/LF collapsing
        step(8'h0A); step(8'h0A);
        repeat (3) step(8'h67);
        check_cur("at_2_27", 2, 27);
        step(8'h0D); step(8'h0A);
        check_cur("crlf", 3, 24);
        step(8'h0A);
        check_cur("lf2", 0, 24);

        // Backspace across row start, then an ignored control byte
        step(8'h0A); step(8'h0A);
        step(8'h08);
        check_cur("bs", 1, 23);
        step(8'h01);
        check_cur("ctl", 1, 23);

        // Randomized traffic with idle gaps
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                5: b = 8'h0D;
                6: b = 8'h0A;
                7: b = 8'h08;
                8: b = 8'h7F;
                9: b = 8'($urandom_range(0, 255));
                default: b = 8'($urandom_range(32, 126));
            endcase
            step(b);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            check("rand_txs", 32'(tx_start), 0);
        end

        // Echo overwrite while transmitter busy
        step(8'h31); step(8'h32);
        repeat (3) begin @(negedge clk); check("held_tx", 32'(tx_start), 0); end
        tx_busy = 0;
        @(negedge clk);
        check("ovr_start", 32'(tx_start), 1);
        check("ovr_data", 32'(tx_data), 32'h32);
        txc = 0;
        repeat (4) begin @(negedge clk); txc += tx_start; end
        check("ovr_single", txc, 0);
        tx_busy = 1;

        // Clear sweep; leaves a CR pending to prove the flag is cleared
        step(8'h0D);
        clear_req = 1; rx_valid = 1; rx_data = 8'h5A;
        @(negedge clk);
        clear_req = 0; rx_valid = 0;
        check("clr_drop", 32'(rx_drop), 1);
        check("clr_busy", 32'(busy), 1);
        busy_cnt = 0; wr_cnt = 0;
        foreach (seen[i]) seen[i] = 0;
        for (int k = 0; k < 300; k++) begin
            if (busy) busy_cnt++;
            if (ram_we) begin
                if (wr_cnt < CELLS) seen[{ram_row, ram_col}] = 1;
                check("clr_addr", 32'({ram_row, ram_col}), wr_cnt);
                check("clr_data", 32'(ram_wdata), 32'h20);
                wr_cnt++;
            end
            if (k == 51) check("sweep_drop", 32'(rx_drop), 1);
            rx_valid = (k == 50); clear_req = (k == 50);
            if (k > 0 && !busy && !ram_we) break;
            @(negedge clk);
        end
        rx_valid = 0; clear_req = 0;
        check("clr_busy_cnt", busy_cnt, CELLS);
        check("clr_writes", wr_cnt, CELLS);
        txc = 0;
        foreach (seen[i]) txc += seen[i];
        check("clr_cover", txc, CELLS);
        mrow = HR; mcol = CS; mcr = 0;
        check_cur("clr_home", HR, CS);
        step(8'h0A);
        check_cur("clr_crflag", 2, 24);

        // Reset mid-sweep aborts immediately
        clear_req = 1; @(negedge clk); clear_req = 0;
        repeat (10) @(negedge clk);
        reset = 1; #1;
        check("abort_we", 32'(ram_we), 0);
        check("abort_busy", 32'(busy), 0);
        @(negedge clk); reset = 0;
        mrow = HR; mcol = CS; mcr = 0;
        check_cur("abort_cur", HR, CS);
        idle_cycles(5);
        step(8'h42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
